// File: rtl/uart_mcu_host.sv
// -----------------------------------------------------------------------------
// uart_mcu_host
//
// Host-side transaction sequencer sitting in front of a byte-wide UART.
// Every accepted request sends a command byte followed by a data byte, leaving
// GAP_CYCLES idle cycles after each byte. Reads (commands 0x20..0x27 and
// 0x50..0x57) then wait up to TIMEOUT_CYCLES for one reply byte. Command 0x00
// is rejected with an error completion and nothing is transmitted.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent waiting for a reply before giving up (>= 1)
//   GAP_CYCLES      idle cycles inserted after each transmitted byte (>= 1)
//
// Ports
//   sys_clk         single clock
//   sys_rst         asynchronous, active-high reset
//   req_valid       request offered
//   req_ready       request can be accepted (high only in IDLE)
//   req_cmd         command byte, latched on acceptance
//   req_data        data byte, latched on acceptance
//   rsp_valid       one-cycle completion pulse
//   rsp_timeout     qualifies rsp_valid: a read got no reply in time
//   rsp_err         qualifies rsp_valid: the command was rejected
//   rsp_data        reply byte of the last read, held until the next completion
//   uart_en         one-cycle transmit strobe to the UART
//   uart_data_in    byte presented to the UART while uart_en is high
//   uart_tx_busy    UART is serialising a byte
//   uart_done       level from the UART; a rising edge means a byte arrived
//   uart_data_out   received byte from the UART
// -----------------------------------------------------------------------------
module uart_mcu_host #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int GAP_CYCLES     = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_cmd,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic       rsp_timeout,
   output logic       rsp_err,
   output logic [7:0] rsp_data,
   output logic       uart_en,
   output logic [7:0] uart_data_in,
   input  logic       uart_tx_busy,
   input  logic       uart_done,
   input  logic [7:0] uart_data_out
);

   // State encoding kept as plain constants so the netlist stays readable in
   // older flows.
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_TX_CMD   = 4'd1;
   localparam logic [3:0] S_WAIT_CMD = 4'd2;
   localparam logic [3:0] S_GAP_CMD  = 4'd3;
   localparam logic [3:0] S_TX_DAT   = 4'd4;
   localparam logic [3:0] S_WAIT_DAT = 4'd5;
   localparam logic [3:0] S_GAP_DAT  = 4'd6;
   localparam logic [3:0] S_WAIT_RSP = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   // Terminal counts: the gap lasts GAP_CYCLES cycles (counts 0..GAP_CYCLES-1)
   // and the reply window lasts TIMEOUT_CYCLES cycles in the same way.
   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [3:0]  r_state;
   logic [7:0]  r_cmd;
   logic [7:0]  r_data;
   logic        r_is_read;
   logic        r_err;
   logic        r_timeout;
   logic [7:0]  r_rsp_data;
   logic [15:0] r_gap_cnt;
   logic [31:0] r_timeout_cnt;
   logic        r_busy_q;
   logic        r_done_q;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [3:0]  w_state_next;
   logic        w_accept;
   logic        w_cmd_is_read;
   logic        w_busy_fall;
   logic        w_done_rise;
   logic        w_gap_last;
   logic        w_timeout_last;
   logic        w_in_gap;

   assign w_accept       = req_valid && (r_state == S_IDLE);
   // 0x20..0x27 and 0x50..0x57 share their upper five bits within each range.
   assign w_cmd_is_read  = (req_cmd[7:3] == 5'b00100) || (req_cmd[7:3] == 5'b01010);
   assign w_busy_fall    = r_busy_q && !uart_tx_busy;
   assign w_done_rise    = uart_done && !r_done_q;
   assign w_gap_last     = (r_gap_cnt == GAP_LAST);
   assign w_timeout_last = (r_timeout_cnt == TIMEOUT_LAST);
   assign w_in_gap       = (r_state == S_GAP_CMD) || (r_state == S_GAP_DAT);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top of an always_comb block keeps every
   // path assigned, so no latch can be inferred for w_state_next.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = (req_cmd == 8'h00) ? S_DONE : S_TX_CMD;
            end
         end
         S_TX_CMD: begin
            if (!uart_tx_busy) w_state_next = S_WAIT_CMD;
         end
         S_WAIT_CMD: begin
            if (w_busy_fall) w_state_next = S_GAP_CMD;
         end
         S_GAP_CMD: begin
            if (w_gap_last) w_state_next = S_TX_DAT;
         end
         S_TX_DAT: begin
            if (!uart_tx_busy) w_state_next = S_WAIT_DAT;
         end
         S_WAIT_DAT: begin
            if (w_busy_fall) w_state_next = S_GAP_DAT;
         end
         S_GAP_DAT: begin
            if (w_gap_last) w_state_next = r_is_read ? S_WAIT_RSP : S_DONE;
         end
         S_WAIT_RSP: begin
            if (w_done_rise || w_timeout_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequential state, counters and captured values
   // ---------------------------------------------------------------------------
   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state       <= S_IDLE;
         r_cmd         <= 8'h00;
         r_data        <= 8'h00;
         r_is_read     <= 1'b0;
         r_err         <= 1'b0;
         r_timeout     <= 1'b0;
         r_rsp_data    <= 8'h00;
         r_gap_cnt     <= 16'h0000;
         r_timeout_cnt <= 32'h0000_0000;
         r_busy_q      <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_busy_q <= uart_tx_busy;

         // The gap counter restarts on every state change, so each gap state
         // always begins counting from zero.
         if (w_state_next != r_state) begin
            r_gap_cnt <= 16'h0000;
         end else if (w_in_gap) begin
            r_gap_cnt <= r_gap_cnt + 16'h0001;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cmd     <= req_cmd;
                  r_data    <= req_data;
                  r_is_read <= w_cmd_is_read;
                  r_err     <= (req_cmd == 8'h00);
                  r_timeout <= 1'b0;
               end
            end
            S_GAP_DAT: begin
               if (w_gap_last) r_timeout_cnt <= 32'h0000_0000;
            end
            S_WAIT_RSP: begin
               // A reply arriving in the last window cycle still counts.
               if (w_done_rise) begin
                  r_rsp_data <= uart_data_out;
               end else if (w_timeout_last) begin
                  r_timeout  <= 1'b1;
                  r_rsp_data <= 8'h00;
               end else if (r_timeout_cnt != 32'hFFFF_FFFF) begin
                  r_timeout_cnt <= r_timeout_cnt + 32'h0000_0001;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Edge-detect history for uart_done. It deliberately has no reset: it keeps
   // following uart_done through reset, so a level that is already high when
   // reset releases is never mistaken for a fresh reply. Rises seen outside
   // WAIT_RSP are absorbed here and never reach rsp_data.
   // NOTE: a register that carries no state worth restoring is left out of the
   // reset branch; resetting it would create a false edge on release.
   always_ff @(posedge sys_clk) begin
      r_done_q <= uart_done;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign req_ready   = (r_state == S_IDLE);
   assign rsp_valid   = (r_state == S_DONE);
   assign rsp_timeout = rsp_valid && r_timeout;
   assign rsp_err     = rsp_valid && r_err;
   assign rsp_data    = r_rsp_data;

   // The strobe is only raised once the UART is idle; leaving the TX state on
   // that same cycle limits it to exactly one cycle.
   assign uart_en      = ((r_state == S_TX_CMD) || (r_state == S_TX_DAT)) && !uart_tx_busy;
   assign uart_data_in = (r_state == S_TX_CMD) ? r_cmd  :
                         (r_state == S_TX_DAT) ? r_data : 8'h00;

endmodule

// File: tb/tb_uart_mcu_host.sv
// -----------------------------------------------------------------------------
// tb_uart_mcu_host
//
// Self-checking bench for uart_mcu_host. A small UART model answers uart_en
// with a 10-cycle busy window and logs the transmitted bytes; a monitor logs
// every completion pulse. Expected completion cycle, flags and data are derived
// from the transaction rules (byte order, gap length, reply window).
// -----------------------------------------------------------------------------
module tb_uart_mcu_host;

   localparam int TO   = 200;
   localparam int GAP  = 16;
   localparam int BUSY = 10;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_cmd;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic       rsp_timeout;
   logic       rsp_err;
   logic [7:0] rsp_data;
   logic       uart_en;
   logic [7:0] uart_data_in;
   logic       uart_tx_busy;
   logic       uart_done;
   logic [7:0] uart_data_out;

   int n_checks = 0;
   int n_fail   = 0;

   uart_mcu_host #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_cmd       (req_cmd),
      .req_data      (req_data),
      .rsp_valid     (rsp_valid),
      .rsp_timeout   (rsp_timeout),
      .rsp_err       (rsp_err),
      .rsp_data      (rsp_data),
      .uart_en       (uart_en),
      .uart_data_in  (uart_data_in),
      .uart_tx_busy  (uart_tx_busy),
      .uart_done     (uart_done),
      .uart_data_out (uart_data_out)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycle index: value seen during a cycle is the number of rising edges so far.
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // UART model: en seen mid-cycle -> busy for the next BUSY cycles.
   // ---------------------------------------------------------------------------
   logic [7:0] tx_q[$];
   int         n_falls  = 0;
   int         fall_cyc = 0;

   initial begin : uart_model
      int   busy_left;
      logic en_seen;
      busy_left    = 0;
      uart_tx_busy = 1'b0;
      forever begin
         @(negedge sys_clk);
         en_seen = uart_en;
         if (en_seen === 1'b1) tx_q.push_back(uart_data_in);
         @(posedge sys_clk);
         #1;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               uart_tx_busy = 1'b0;
               n_falls++;
               fall_cyc = cyc;
            end
         end else if (en_seen === 1'b1) begin
            uart_tx_busy = 1'b1;
            busy_left    = BUSY;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Completion monitor
   // ---------------------------------------------------------------------------
   typedef struct {
      int         c;
      logic       to;
      logic       er;
      logic [7:0] d;
   } rsp_t;
   rsp_t rsp_q[$];

   initial begin : rsp_monitor
      rsp_t r;
      forever begin
         @(negedge sys_clk);
         if (rsp_valid === 1'b1) begin
            r.c  = cyc;
            r.to = rsp_timeout;
            r.er = rsp_err;
            r.d  = rsp_data;
            rsp_q.push_back(r);
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Reference rule and stimulus helpers
   // ---------------------------------------------------------------------------
   function automatic bit is_read(input logic [7:0] cmd);
      return ((cmd >= 8'h20) && (cmd <= 8'h27)) || ((cmd >= 8'h50) && (cmd <= 8'h57));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #2;
   endtask

   task automatic issue(input logic [7:0] cmd, input logic [7:0] dat,
                        output logic rdy, output int acc);
      req_cmd   = cmd;
      req_data  = dat;
      req_valid = 1'b1;
      @(negedge sys_clk);
      rdy = req_ready;
      acc = cyc;
      tick(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_falls(input int target, output logic ok);
      int k;
      k = 0;
      while (n_falls < target && k < 300) begin
         tick(1);
         k++;
      end
      ok = (n_falls >= target);
   endtask

   task automatic wait_rsp(input int budget, output logic ok);
      int k;
      k = 0;
      while (rsp_q.size() == 0 && k < budget) begin
         tick(1);
         k++;
      end
      ok = (rsp_q.size() > 0);
   endtask

   // One full transaction, optionally answered delay cycles after the second
   // byte finishes, checked against the expected outcome.
   task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                          input bit has_reply, input int delay, input logic [7:0] reply);
      int n0, acc, f, r, exp_c, wstart, deadline, exp_n;
      logic rdy, ok, exp_to;
      logic [7:0] exp_d;
      bit rd;
      rd = is_read(cmd);
      n0 = n_falls;
      f  = 0;
      r  = -1;
      tx_q.delete();
      rsp_q.delete();
      issue(cmd, dat, rdy, acc);
      n_checks++;
      if (rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s req_ready: got %b expected 1", tag, rdy);
      end
      if (cmd != 8'h00) begin
         wait_falls(n0 + 2, ok);
         n_checks++;
         if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s tx_complete: got %0d byte ends expected 2", tag, n_falls - n0);
         end
         f = fall_cyc;
         if (has_reply) begin
            tick(delay);
            uart_data_out = reply;
            uart_done     = 1'b1;
            r             = cyc;
         end
      end
      wait_rsp(TO + 200, ok);
      tick(3);
      uart_done = 1'b0;

      exp_d  = 8'h00;
      exp_to = 1'b0;
      if (cmd == 8'h00) begin
         exp_c = acc + 1;
      end else if (!rd) begin
         exp_c = f + GAP + 1;
      end else begin
         wstart   = f + GAP + 1;
         deadline = wstart + TO - 1;
         if (has_reply && r >= wstart && r <= deadline) begin
            exp_c = r + 1;
            exp_d = reply;
         end else begin
            exp_c  = deadline + 1;
            exp_to = 1'b1;
         end
      end
      exp_n = (cmd == 8'h00) ? 0 : 2;

      n_checks++;
      if (tx_q.size() != exp_n) begin
         n_fail++;
         $display("FAIL %s tx_count: got %0d expected %0d", tag, tx_q.size(), exp_n);
      end else if (exp_n == 2) begin
         n_checks++;
         if (tx_q[0] !== cmd || tx_q[1] !== dat) begin
            n_fail++;
            $display("FAIL %s tx_bytes: got %h %h expected %h %h", tag, tx_q[0], tx_q[1], cmd, dat);
         end
      end
      n_checks++;
      if (rsp_q.size() != 1) begin
         n_fail++;
         $display("FAIL %s rsp_count: got %0d expected 1", tag, rsp_q.size());
      end else begin
         n_checks++;
         if (rsp_q[0].c !== exp_c) begin
            n_fail++;
            $display("FAIL %s rsp_cycle: got %0d expected %0d", tag, rsp_q[0].c, exp_c);
         end
         n_checks++;
         if (rsp_q[0].to !== exp_to || rsp_q[0].er !== (cmd == 8'h00)) begin
            n_fail++;
            $display("FAIL %s rsp_flags: got to=%b err=%b expected to=%b err=%b",
                     tag, rsp_q[0].to, rsp_q[0].er, exp_to, (cmd == 8'h00));
         end
         if (rd) begin
            n_checks++;
            if (rsp_q[0].d !== exp_d) begin
               n_fail++;
               $display("FAIL %s rsp_data: got %h expected %h", tag, rsp_q[0].d, exp_d);
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      tick(3);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_timeout, rsp_err, uart_en} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ready/valid/to/err/en=%b expected 10000",
                  {req_ready, rsp_valid, rsp_timeout, rsp_err, uart_en});
      end
      n_checks++;
      if (rsp_data !== 8'h00 || uart_data_in !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got rsp_data=%h uart_data_in=%h expected 00 00",
                  rsp_data, uart_data_in);
      end
      uart_done = 1'b1;
      tick(2);
      sys_rst = 1'b0;
      tick(2);
      uart_done = 1'b0;
      tick(2);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b rsp=%0d expected ready=1 rsp=0",
                  req_ready, rsp_q.size());
      end
   endtask

   task automatic test_write();
      run_txn("write_30_a5", 8'h30, 8'hA5, 1'b0, 0, 8'h00);
   endtask

   task automatic test_read();
      run_txn("read_50_3c", 8'h50, 8'h00, 1'b1, 50, 8'h3C);
   endtask

   task automatic test_timeout();
      run_txn("read_21_timeout", 8'h21, 8'h00, 1'b0, 0, 8'h00);
   endtask

   task automatic test_cmd_zero();
      run_txn("cmd_zero", 8'h00, 8'h12, 1'b0, 0, 8'h00);
   endtask

   task automatic test_window_edges();
      run_txn("reply_first_cycle", 8'h20, 8'h01, 1'b1, GAP + 1, 8'h81);
      run_txn("reply_before_window", 8'h26, 8'h02, 1'b1, GAP, 8'h92);
      run_txn("reply_ties_timeout", 8'h27, 8'h03, 1'b1, GAP + TO, 8'h5E);
      run_txn("reply_after_timeout", 8'h57, 8'h04, 1'b1, GAP + TO + 1, 8'h6F);
   endtask

   task automatic test_stray_done();
      int n0, acc, r;
      logic rdy, ok;
      n0 = n_falls;
      tx_q.delete();
      rsp_q.delete();
      issue(8'h52, 8'h11, rdy, acc);
      wait_falls(n0 + 1, ok);
      tick(GAP + 1);                 // first data-byte cycle
      uart_data_out = 8'hEE;
      uart_done     = 1'b1;
      tick(3);
      uart_done     = 1'b0;
      wait_falls(n0 + 2, ok);
      tick(30);
      uart_data_out = 8'h77;
      uart_done     = 1'b1;
      r             = cyc;
      wait_rsp(TO + 200, ok);
      tick(3);
      uart_done = 1'b0;
      n_checks++;
      if (rsp_q.size() != 1) begin
         n_fail++;
         $display("FAIL stray rsp_count: got %0d expected 1", rsp_q.size());
      end else begin
         n_checks++;
         if (rsp_q[0].d !== 8'h77 || rsp_q[0].to !== 1'b0) begin
            n_fail++;
            $display("FAIL stray rsp: got data=%h to=%b expected data=77 to=0",
                     rsp_q[0].d, rsp_q[0].to);
         end
         n_checks++;
         if (rsp_q[0].c !== r + 1) begin
            n_fail++;
            $display("FAIL stray rsp_cycle: got %0d expected %0d", rsp_q[0].c, r + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n0, acc, f, k;
      logic rdy, ok, seen;
      n0 = n_falls;
      tx_q.delete();
      rsp_q.delete();
      issue(8'h41, 8'h5A, rdy, acc);
      req_valid = 1'b1;
      req_cmd   = 8'h00;
      req_data  = 8'hFF;
      seen = 1'b0;
      k    = 0;
      while (n_falls < n0 + 2 && k < 300) begin
         tick(1);
         k++;
         if (req_ready !== 1'b0) seen = 1'b1;
      end
      f = fall_cyc;
      repeat (GAP) begin
         tick(1);
         if (req_ready !== 1'b0) seen = 1'b1;
      end
      req_valid = 1'b0;
      wait_rsp(50, ok);
      tick(5);
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b ready_busy: got ready high mid-transaction expected low");
      end
      n_checks++;
      if (tx_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b tx_count: got %0d expected 2", tx_q.size());
      end
      n_checks++;
      if (rsp_q.size() != 1) begin
         n_fail++;
         $display("FAIL b2b rsp_count: got %0d expected 1", rsp_q.size());
      end else begin
         n_checks++;
         if (rsp_q[0].c !== f + GAP + 1 || rsp_q[0].er !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b rsp: got cycle=%0d err=%b expected cycle=%0d err=0",
                     rsp_q[0].c, rsp_q[0].er, f + GAP + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n0, acc;
      logic rdy, ok, seen;
      n0 = n_falls;
      issue(8'h55, 8'h01, rdy, acc);
      wait_falls(n0 + 2, ok);
      tick(GAP + 5);                 // inside the reply window
      rsp_q.delete();
      sys_rst = 1'b1;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_timeout, rsp_err, uart_en} !== 5'b10000) begin
         n_fail++;
         $display("FAIL midreset_ctrl: got ready/valid/to/err/en=%b expected 10000",
                  {req_ready, rsp_valid, rsp_timeout, rsp_err, uart_en});
      end
      n_checks++;
      if (rsp_data !== 8'h00 || uart_data_in !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_data: got rsp_data=%h uart_data_in=%h expected 00 00",
                  rsp_data, uart_data_in);
      end
      tick(1);
      uart_data_out = 8'h99;
      uart_done     = 1'b1;
      tick(3);
      sys_rst = 1'b0;
      seen    = 1'b0;
      repeat (20) begin
         tick(1);
         if (req_ready !== 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (rsp_q.size() != 0 || seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_release: got rsp=%0d ready_dropped=%b expected rsp=0 ready_dropped=0",
                  rsp_q.size(), seen);
      end
      uart_done = 1'b0;
      tick(2);
      run_txn("after_reset", 8'h53, 8'h44, 1'b1, 40, 8'hC3);
   endtask

   task automatic test_random();
      logic [7:0] bounds [8];
      logic [7:0] cmd, dat, reply;
      int kind, delay;
      bit rd;
      bounds = '{8'h1F, 8'h20, 8'h27, 8'h28, 8'h4F, 8'h50, 8'h57, 8'h58};
      for (int i = 0; i < 14; i++) begin
         kind = int'($urandom_range(0, 2));
         if (kind == 0)      cmd = 8'($urandom_range(0, 255));
         else if (kind == 1) cmd = bounds[$urandom_range(0, 7)];
         else                cmd = (($urandom_range(0, 1) == 0) ? 8'h20 : 8'h50) + 8'($urandom_range(0, 7));
         dat   = 8'($urandom_range(0, 255));
         reply = 8'($urandom_range(0, 255));
         delay = int'($urandom_range(1, GAP + TO + 20));
         rd    = is_read(cmd);
         run_txn($sformatf("random_%0d_cmd%h", i, cmd), cmd, dat, rd, delay, reply);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      sys_rst       = 1'b1;
      req_valid     = 1'b0;
      req_cmd       = 8'h00;
      req_data      = 8'h00;
      uart_done     = 1'b0;
      uart_data_out = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_cmd_zero();
      test_window_edges();
      test_stray_done();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
